// File: rtl/uart_tx_framer_configurable_if.sv
// Byte/config handshake between a host-side byte source and the UART TX framer.
// Signal names mirror the framer's port names so the source side reads naturally.
interface uart_tx_framer_configurable_if #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DIVISOR_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]    i_data;
  logic                     i_valid;
  logic                     o_ready;
  logic [DIVISOR_WIDTH-1:0] i_divisor;
  logic                     i_parity_en;
  logic                     i_parity_odd;
  logic                     i_stop2;

  modport master (
    output i_data, i_valid, i_divisor, i_parity_en, i_parity_odd, i_stop2,
    input  o_ready
  );

  modport slave (
    input  i_data, i_valid, i_divisor, i_parity_en, i_parity_odd, i_stop2,
    output o_ready
  );
endinterface

// File: rtl/uart_tx_framer_configurable.sv
// UART transmitter with valid/ready byte intake and per-frame latched baud divisor,
// parity mode and stop-bit count. Control FSM and serialiser live in one block.
module uart_tx_framer_configurable #(
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned DIVISOR_WIDTH     = 16,
  parameter int unsigned BIT_COUNTER_WIDTH = 4
) (
  input  logic                               i_clock,
  input  logic                               i_resetL,
  uart_tx_framer_configurable_if.slave       bus_if,
  output logic                               o_TX,
  output logic                               o_busy,
  output logic                               o_done
);

  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned DVW = DIVISOR_WIDTH;
  localparam int unsigned BCW = BIT_COUNTER_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // Frame format captured at the handshake and held for the whole frame.
  typedef struct packed {
    logic [DVW-1:0] div;
    logic           par_en;
    logic           par_bit;
    logic           stop2;
  } frame_cfg_t;

  state_e           state_q, state_d;
  frame_cfg_t       cfg_q,   cfg_d;
  logic [DW-1:0]    shift_q, shift_d;
  logic [DVW-1:0]   cnt_q,   cnt_d;
  logic [BCW-1:0]   idx_q,   idx_d;
  logic             tx_q,    tx_d;
  logic             ready_q, ready_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             bit_end_c;

  always_ff @(posedge i_clock or negedge i_resetL) begin
    if (!i_resetL) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    // Bit-period timer: wraps to 0 on the last clock of every bit.
    bit_end_c = (cnt_q == (cfg_q.div - DVW'(1)));
    cnt_d     = bit_end_c ? '0 : (cnt_q + DVW'(1));

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus_if.i_valid && ready_q) begin
          shift_d       = bus_if.i_data;
          cfg_d.div     = (bus_if.i_divisor == '0) ? DVW'(1) : bus_if.i_divisor;
          cfg_d.par_en  = bus_if.i_parity_en;
          cfg_d.par_bit = (^bus_if.i_data) ^ bus_if.i_parity_odd;
          cfg_d.stop2   = bus_if.i_stop2;
          idx_d         = '0;
          state_d       = ST_START;
          tx_d          = 1'b0;
          ready_d       = 1'b0;
          busy_d        = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end_c) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end

      // Payload leaves LSB first; the shifter keeps the next bit at position 1.
      ST_DATA: begin
        if (bit_end_c) begin
          if (idx_q == BCW'(DW - 1)) begin
            idx_d = '0;
            if (cfg_q.par_en) begin
              state_d = ST_PARITY;
              tx_d    = cfg_q.par_bit;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + BCW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end

      ST_PARITY: begin
        if (bit_end_c) begin
          state_d = ST_STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end

      // idx counts stop bits here so a second stop period reuses the same timer.
      ST_STOP: begin
        if (bit_end_c) begin
          if (cfg_q.stop2 && (idx_q == '0)) begin
            idx_d = BCW'(1);
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
            tx_d    = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus_if.o_ready = ready_q;
  assign o_TX           = tx_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_uart_tx_framer_configurable.sv
// Scoreboarded bench for the UART TX framer: stimulus queues expected frames, a
// monitor rebuilds the expected line level per clock from frame arithmetic.
module tb_uart_tx_framer_configurable;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_framer_configurable_if #(.DATA_WIDTH(8), .DIVISOR_WIDTH(16)) bus8 ();
  uart_tx_framer_configurable_if #(.DATA_WIDTH(5), .DIVISOR_WIDTH(16)) bus5 ();

  logic tx8, busy8, done8;
  logic tx5, busy5, done5;

  uart_tx_framer_configurable #(
    .DATA_WIDTH(8), .DIVISOR_WIDTH(16), .BIT_COUNTER_WIDTH(4)
  ) dut8 (
    .i_clock (clk),
    .i_resetL(rst_n),
    .bus_if  (bus8),
    .o_TX    (tx8),
    .o_busy  (busy8),
    .o_done  (done8)
  );

  uart_tx_framer_configurable #(
    .DATA_WIDTH(5), .DIVISOR_WIDTH(16), .BIT_COUNTER_WIDTH(4)
  ) dut5 (
    .i_clock (clk),
    .i_resetL(rst_n),
    .bus_if  (bus5),
    .o_TX    (tx5),
    .o_busy  (busy5),
    .o_done  (done5)
  );

  typedef struct {
    logic [8:0] data;
    int         dv;
    bit         pen;
    bit         odd;
    bit         stop2;
    bit         b2b;
    bit         abort;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_seen = 0;
  int frames_expected_done = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done8 === 1'b1) done_seen <= done_seen + 1;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int eff_div(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int frame_len(input int w, input int dv, input bit pen, input bit stop2);
    return dv * (1 + w + (pen ? 1 : 0) + (stop2 ? 2 : 1));
  endfunction

  // Line level at clock k of a frame, derived from bit slot = k / D.
  function automatic logic exp_level(input logic [8:0] d, input int w, input int dv,
                                     input bit pen, input bit odd, input int k);
    int   slot;
    int   ones;
    logic [8:0] dd;
    slot = k / dv;
    dd   = d;
    ones = 0;
    for (int i = 0; i < w; i++) ones += (dd[i] === 1'b1) ? 1 : 0;
    if (slot == 0) return 1'b0;
    if (slot <= w) return dd[slot-1];
    if (pen && slot == w + 1) return ((ones % 2) == 1) ^ odd;
    return 1'b1;
  endfunction

  task automatic send(input logic [7:0] d, input int dv, input bit pen, input bit odd,
                      input bit stop2, input bit hold, input bit b2b, input bit abort);
    frame_t f;
    int n;
    @(negedge clk);
    bus8.i_data       = d;
    bus8.i_divisor    = 16'(dv);
    bus8.i_parity_en  = pen;
    bus8.i_parity_odd = odd;
    bus8.i_stop2      = stop2;
    bus8.i_valid      = 1'b1;
    f.data  = 9'(d);
    f.dv    = eff_div(dv);
    f.pen   = pen;
    f.odd   = odd;
    f.stop2 = stop2;
    f.b2b   = b2b;
    f.abort = abort;
    exp_q.push_back(f);
    if (!abort) frames_expected_done++;
    n = 0;
    while (bus8.o_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("send_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!hold) bus8.i_valid = 1'b0;
  endtask

  // Monitor: a frame starts at the first clock busy is seen high.
  initial begin : monitor
    frame_t f;
    int len, bad_k, start_cyc, last_done_cyc, n, dn;
    bit busy_ok;
    last_done_cyc = -100;
    forever begin
      @(negedge clk);
      if (busy8 === 1'b1) begin
        start_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          n = 0;
          while (busy8 === 1'b1 && n < 2000) begin @(negedge clk); n++; end
        end else begin
          f = exp_q.pop_front();
          if (f.abort) begin
            dn = 0;
            n  = 0;
            while (busy8 === 1'b1 && n < 2000) begin
              if (done8 === 1'b1) dn++;
              @(negedge clk);
              n++;
            end
            check("abort_no_done", dn, 0);
            check("abort_busy_low", 32'(busy8), 0);
          end else begin
            len     = frame_len(8, f.dv, f.pen, f.stop2);
            bad_k   = -1;
            busy_ok = 1'b1;
            for (int k = 0; k < len; k++) begin
              if (k > 0) @(negedge clk);
              if (tx8 !== exp_level(f.data, 8, f.dv, f.pen, f.odd, k) && bad_k < 0) bad_k = k;
              if (busy8 !== 1'b1 || done8 !== 1'b0 || bus8.o_ready !== 1'b0) busy_ok = 1'b0;
            end
            check("frame_first_bad_clock", bad_k, -1);
            check("busy_ready_during_frame", 32'(busy_ok), 1);
            @(negedge clk);
            check("done_at_frame_end", 32'(done8), 1);
            check("busy_low_at_end", 32'(busy8), 0);
            check("ready_at_end", 32'(bus8.o_ready), 1);
            check("tx_idle_at_end", 32'(tx8), 1);
            if (f.b2b) check("b2b_idle_gap", start_cyc - last_done_cyc, 1);
            last_done_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy8 === 1'b1) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("drain_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : stimulus
    int bad, bc;
    bus8.i_data = '0; bus8.i_valid = 1'b0; bus8.i_divisor = '0;
    bus8.i_parity_en = 1'b0; bus8.i_parity_odd = 1'b0; bus8.i_stop2 = 1'b0;
    bus5.i_data = '0; bus5.i_valid = 1'b0; bus5.i_divisor = '0;
    bus5.i_parity_en = 1'b0; bus5.i_parity_odd = 1'b0; bus5.i_stop2 = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx8), 1);
    check("reset_ready", 32'(bus8.o_ready), 1);
    check("reset_busy", 32'(busy8), 0);
    check("reset_done", 32'(done8), 0);
    rst_n = 1'b1;

    // Directed frames: 0xA5 plain, 0x07 even/odd parity, D=0 with two stops.
    send(8'hA5, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h07, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h07, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'hFF, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // Back-to-back with valid held; config scrambled while the first frame runs.
    send(8'h12, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus8.i_divisor = 16'd8;
    bus8.i_data = 8'($urandom);
    bus8.i_parity_en = 1'b1;
    bus8.i_stop2 = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h34, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    // Reset in the middle of data bit 3 (bit 3 of 0x16 is 0, so the line would be low).
    send(8'h16, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midframe_reset_tx", 32'(tx8), 1);
    check("midframe_reset_ready", 32'(bus8.o_ready), 1);
    check("midframe_reset_busy", 32'(busy8), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send(8'hC3, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // Randomised frames with random idle gaps.
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'($urandom), int'($urandom_range(0, 5)), 1'($urandom), 1'($urandom),
           1'($urandom), 1'b0, 1'b0, 1'b0);
    end
    drain();
    check("done_pulse_count", done_seen, frames_expected_done);

    // Five-bit payload instance: 5'h15, odd parity, D=2.
    @(negedge clk);
    bus5.i_data = 5'h15; bus5.i_divisor = 16'd2; bus5.i_parity_en = 1'b1;
    bus5.i_parity_odd = 1'b1; bus5.i_stop2 = 1'b0; bus5.i_valid = 1'b1;
    check("w5_ready_idle", 32'(bus5.o_ready), 1);
    @(posedge clk);
    #1;
    bus5.i_valid = 1'b0;
    bad = -1;
    bc  = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (tx5 !== exp_level(9'h015, 5, 2, 1'b1, 1'b1, k) && bad < 0) bad = k;
      if (busy5 === 1'b1) bc++;
    end
    check("w5_first_bad_clock", bad, -1);
    check("w5_busy_clocks", bc, 16);
    @(negedge clk);
    check("w5_done", 32'(done5), 1);
    check("w5_busy_end", 32'(busy5), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
